// File: rtl/kbd_text_pkg.sv
// Shared types for the keyboard text path: scancode constants, the edit command
// carried through the FIFO, decode/writer state encodings and the printable-key test.
package kbd_text_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_SPACE = 8'h29;

  typedef enum logic [1:0] {OP_PUT, OP_BKSP, OP_ENTER, OP_CLEAR} cmd_op_t;

  typedef struct packed {
    cmd_op_t    op;
    logic [7:0] code;
  } cmd_t;

  typedef enum logic [1:0] {D_IDLE, D_BREAK, D_EXT} dec_state_t;

  typedef enum logic [1:0] {W_IDLE, W_PUT, W_BKSP, W_CLEAR} wr_state_t;

  // Set-2 make codes of letters, digits, space and the main punctuation keys.
  function automatic logic is_printable(input logic [7:0] code);
    case (code)
      8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
      8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
      8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
      8'h29, 8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52,
      8'h41, 8'h49, 8'h4A: is_printable = 1'b1;
      default:             is_printable = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/kbd_cmd_fifo.sv
// Small synchronous show-ahead FIFO for edit commands; a push into a full FIFO
// is accepted only when a pop happens in the same cycle, otherwise it is dropped.
module kbd_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk100,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic             full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & ~do_push;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk100) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kbd_text_scheduler.sv
// Turns PS/2 scancodes into edit commands and writes them into the character RAM,
// yielding the RAM port to VGA fetch. Optional key-click tone: define KBD_TONE_EN.
module kbd_text_scheduler
  import kbd_text_pkg::*;
#(
  parameter int         COLS         = 80,
  parameter int         ROWS         = 30,
  parameter int         FIFO_DEPTH   = 4,
  parameter int         CLICK_CYCLES = 2_000_000,
  parameter logic [6:0] CLICK_PW     = 7'd64
) (
  input  logic        clk100,
  input  logic        reset,
  input  logic [7:0]  scan,
  input  logic        scan_valid,
  input  logic        vga_rd_req,
  output logic        ram_we,
  output logic [11:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy,
  output logic        overflow,
  output logic [6:0]  pulse_width
);

  dec_state_t  d_state, d_next;
  wr_state_t   w_state, w_next;
  logic        push, pop, fifo_empty, fifo_drop, pending;
  cmd_t        push_cmd, fifo_out;
  logic [7:0]  cmd_code, wdata_c;
  logic [11:0] sweep_addr, sweep_n, addr_c;
  logic [6:0]  col_n, bk_col, adv_col;
  logic [4:0]  row_n, bk_row, adv_row, next_row;

  function automatic logic [11:0] addr_of(input logic [6:0] col, input logic [4:0] row);
    addr_of = 12'(row) * 12'(COLS) + 12'(col);
  endfunction

  always_comb begin
    d_next   = d_state;
    push     = 1'b0;
    push_cmd = '{op: OP_PUT, code: scan};
    if (scan_valid) begin
      case (d_state)
        D_IDLE: begin
          if (scan == SC_BREAK)    d_next = D_BREAK;
          else if (scan == SC_EXT) d_next = D_EXT;
          else begin
            push = 1'b1;
            case (scan)
              SC_BKSP:  push_cmd.op = OP_BKSP;
              SC_ENTER: push_cmd.op = OP_ENTER;
              SC_ESC:   push_cmd.op = OP_CLEAR;
              default:  push = is_printable(scan);
            endcase
          end
        end
        D_BREAK: d_next = D_IDLE;
        D_EXT:   d_next = (scan == SC_BREAK) ? D_BREAK : D_IDLE;
        default: d_next = D_IDLE;
      endcase
    end
  end

  kbd_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(cmd_t))) u_fifo (
    .clk100 (clk100),
    .reset  (reset),
    .push   (push),
    .wdata  (push_cmd),
    .pop    (pop),
    .rdata  (fifo_out),
    .empty  (fifo_empty),
    .drop   (fifo_drop)
  );

  // Cursor neighbours: one step forward (with line and screen wrap) and one step back.
  assign next_row = (cursor_row == 5'(ROWS-1)) ? 5'd0 : cursor_row + 5'd1;
  assign adv_col  = (cursor_col == 7'(COLS-1)) ? 7'd0 : cursor_col + 7'd1;
  assign adv_row  = (cursor_col == 7'(COLS-1)) ? next_row : cursor_row;
  assign bk_col   = (cursor_col != 7'd0) ? cursor_col - 7'd1 : 7'(COLS-1);
  assign bk_row   = (cursor_col != 7'd0) ? cursor_row : cursor_row - 5'd1;

  always_comb begin
    w_next  = w_state;
    col_n   = cursor_col;
    row_n   = cursor_row;
    sweep_n = sweep_addr;
    pop     = 1'b0;
    pending = 1'b0;
    addr_c  = '0;
    wdata_c = '0;
    case (w_state)
      W_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          case (fifo_out.op)
            OP_PUT:   w_next = W_PUT;
            OP_BKSP:  w_next = W_BKSP;
            OP_ENTER: begin
              col_n = 7'd0;
              row_n = next_row;
            end
            OP_CLEAR: begin
              w_next  = W_CLEAR;
              sweep_n = '0;
            end
            default:  w_next = W_IDLE;
          endcase
        end
      end
      W_PUT: begin
        pending = 1'b1;
        addr_c  = addr_of(cursor_col, cursor_row);
        wdata_c = cmd_code;
        if (!vga_rd_req) begin
          col_n  = adv_col;
          row_n  = adv_row;
          w_next = W_IDLE;
        end
      end
      W_BKSP: begin
        if (cursor_col == 7'd0 && cursor_row == 5'd0) begin
          w_next = W_IDLE;
        end else begin
          pending = 1'b1;
          addr_c  = addr_of(bk_col, bk_row);
          wdata_c = SC_SPACE;
          if (!vga_rd_req) begin
            col_n  = bk_col;
            row_n  = bk_row;
            w_next = W_IDLE;
          end
        end
      end
      W_CLEAR: begin
        pending = 1'b1;
        addr_c  = sweep_addr;
        wdata_c = SC_SPACE;
        if (!vga_rd_req) begin
          if (sweep_addr == 12'(COLS*ROWS-1)) begin
            col_n  = 7'd0;
            row_n  = 5'd0;
            w_next = W_IDLE;
          end else begin
            sweep_n = sweep_addr + 12'd1;
          end
        end
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      d_state    <= D_IDLE;
      w_state    <= W_IDLE;
      cursor_col <= '0;
      cursor_row <= '0;
      sweep_addr <= '0;
      cmd_code   <= '0;
      overflow   <= 1'b0;
    end else begin
      d_state    <= d_next;
      w_state    <= w_next;
      cursor_col <= col_n;
      cursor_row <= row_n;
      sweep_addr <= sweep_n;
      if (pop) cmd_code <= fifo_out.code;
      overflow   <= overflow | fifo_drop;
    end
  end

  assign ram_we    = pending & ~vga_rd_req;
  assign ram_addr  = addr_c;
  assign ram_wdata = wdata_c;
  assign busy      = (w_state != W_IDLE) | ~fifo_empty;

`ifdef KBD_TONE_EN
  localparam int CW = $clog2(CLICK_CYCLES + 1);
  logic [CW-1:0] click_cnt;

  // Every accepted PUT restarts the click, so fast typing extends the tone.
  always_ff @(posedge clk100) begin
    if (reset)
      click_cnt <= '0;
    else if (push && !fifo_drop && push_cmd.op == OP_PUT)
      click_cnt <= CW'(CLICK_CYCLES);
    else if (click_cnt != '0)
      click_cnt <= click_cnt - CW'(1);
  end

  assign pulse_width = (click_cnt != '0) ? CLICK_PW : 7'd0;
`else
  logic unused_tone_cfg;
  assign unused_tone_cfg = ^{CLICK_PW, CLICK_CYCLES};
  assign pulse_width     = 7'd0;
`endif

endmodule
